// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus between a display scanner (master) and the
// seg_scan_decoder observer (slave), including the decoded frame outputs.
interface seg_scan_decoder_if;
  logic [3:0] pos;
  logic       a, b, c, d, e, f, g;
  logic       dp;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       err;

  modport master (
    output pos, a, b, c, d, e, f, g, dp,
    input  dig0, dig1, dig2, dig3, dp_out, frame_valid, err
  );

  modport slave (
    input  pos, a, b, c, d, e, f, g, dp,
    output dig0, dig1, dig2, dig3, dp_out, frame_valid, err
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Observes multiplexed seven-segment scan lines, debounces each scan slot and
// reconstructs the four displayed BCD digits, committing whole frames atomically.
module seg_scan_decoder #(
  parameter int STABLE  = 4,
  parameter bit POS_LOW = 1'b1,
  parameter bit SEG_LOW = 1'b1
) (
  input logic          clk,
  input logic          reset,
  seg_scan_decoder_if.slave bus
);
  localparam logic [7:0] HOLD_MAX = 8'(STABLE);
  localparam logic [7:0] HOLD_CAP = 8'(STABLE - 1);

  typedef enum logic [1:0] {SETTLE, CAPTURE, HELD, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [11:0]      smp_q, smp_d;
  logic [11:0]      smp_prev_q, smp_prev_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [3:0]       seen_q, seen_d;
  logic             ferr_q, ferr_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       dp_out_q, dp_out_d;
  logic             frame_valid_q, frame_valid_d;
  logic             err_q, err_d;

  logic             chg;
  state_t           settle_next;
  logic [3:0]       cap_pos;
  logic [4:0]       dec;
  logic [1:0]       cap_idx;

  // Returns {invalid, code}: digits 0-9, blank = 4'hF, anything else 4'hE.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {1'b0, 4'd0};
      7'b0110000: decode = {1'b0, 4'd1};
      7'b1101101: decode = {1'b0, 4'd2};
      7'b1111001: decode = {1'b0, 4'd3};
      7'b0110011: decode = {1'b0, 4'd4};
      7'b1011011: decode = {1'b0, 4'd5};
      7'b1011111: decode = {1'b0, 4'd6};
      7'b1110000: decode = {1'b0, 4'd7};
      7'b1111111: decode = {1'b0, 4'd8};
      7'b1111011: decode = {1'b0, 4'd9};
      7'b0000000: decode = {1'b0, 4'hF};
      default:    decode = {1'b1, 4'hE};
    endcase
  endfunction

  always_comb begin
    smp_d[11:8] = POS_LOW ? ~bus.pos : bus.pos;
    smp_d[7:0]  = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.dp} ^ {8{SEG_LOW}};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    smp_prev_d    = smp_q;
    shadow_d      = shadow_q;
    shadow_dp_d   = shadow_dp_q;
    seen_d        = seen_q;
    ferr_d        = ferr_q;
    dig_d         = dig_q;
    dp_out_d      = dp_out_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;

    chg         = (smp_q != smp_prev_q);
    hold_d      = chg ? 8'd0 : ((hold_q >= HOLD_MAX) ? hold_q : hold_q + 8'd1);
    settle_next = (hold_d >= HOLD_CAP) ? CAPTURE : SETTLE;

    // The captured sample is smp_prev, which was already proven stable.
    cap_pos = smp_prev_q[11:8];
    dec     = decode(smp_prev_q[7:1]);
    cap_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cap_pos[i]) cap_idx = 2'(i);
    end

    case (state_q)
      SETTLE: state_d = chg ? SETTLE : settle_next;
      CAPTURE: begin
        if ($onehot(cap_pos)) begin
          shadow_d[cap_idx]    = dec[3:0];
          shadow_dp_d[cap_idx] = smp_prev_q[0];
          seen_d[cap_idx]      = 1'b1;
          if (dec[4]) ferr_d = 1'b1;
        end else if (cap_pos != 4'b0000) begin
          ferr_d = 1'b1;
        end
        if (seen_d == 4'b1111) begin
          dig_d         = shadow_d;
          dp_out_d      = shadow_dp_d;
          err_d         = ferr_d;
          seen_d        = 4'b0000;
          ferr_d        = 1'b0;
          frame_valid_d = 1'b1;
          state_d       = COMMIT;
        end else begin
          state_d = chg ? SETTLE : HELD;
        end
      end
      // A change that landed during CAPTURE shows up here as a cleared hold.
      COMMIT: begin
        if (chg)                    state_d = SETTLE;
        else if (hold_q == HOLD_MAX) state_d = HELD;
        else                        state_d = settle_next;
      end
      HELD:    state_d = chg ? SETTLE : HELD;
      default: state_d = SETTLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shadow digit store is reset too, so a reset always discards a partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SETTLE;
      smp_q         <= '0;
      smp_prev_q    <= '0;
      hold_q        <= '0;
      shadow_q      <= '1;
      shadow_dp_q   <= '0;
      seen_q        <= '0;
      ferr_q        <= 1'b0;
      dig_q         <= '1;
      dp_out_q      <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      smp_q         <= smp_d;
      smp_prev_q    <= smp_prev_d;
      hold_q        <= hold_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      seen_q        <= seen_d;
      ferr_q        <= ferr_d;
      dig_q         <= dig_d;
      dp_out_q      <= dp_out_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
    end
  end

  assign bus.dig0        = dig_q[0];
  assign bus.dig1        = dig_q[1];
  assign bus.dig2        = dig_q[2];
  assign bus.dig3        = dig_q[3];
  assign bus.dp_out      = dp_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: common-anode, active-low scan lines,
// STABLE = 4, expected frames computed by hand.
module tb_seg_scan_decoder;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   fv_count = 0;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(.STABLE(4), .POS_LOW(1'b1), .SEG_LOW(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_count++;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Lit segments and selected digit given active-high; pins are active-low.
  task automatic drive(input logic [3:0] pos_oh, input logic [6:0] seg, input logic dpv);
    bus.pos = ~pos_oh;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = ~seg;
    bus.dp = ~dpv;
  endtask

  task automatic slot(input int idx, input logic [6:0] seg, input logic dpv, input int n);
    drive(4'(1 << idx), seg, dpv);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b0000, 7'b0000000, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input int d3, input int d2, input int d1, input int d0,
                            input logic [3:0] dpm);
    slot(3, seg_of(d3), dpm[3], 10);
    slot(2, seg_of(d2), dpm[2], 10);
    slot(1, seg_of(d1), dpm[1], 10);
    slot(0, seg_of(d0), dpm[0], 10);
    idle(5);
  endtask

  function automatic logic [15:0] digs();
    return {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if (digs() !== 16'hFFFF) begin errors++; $display("FAIL reset_digits: got %h want ffff", digs()); end
    checks++;
    if ({bus.dp_out, bus.frame_valid, bus.err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got dp_out=%b fv=%b err=%b want 0", bus.dp_out, bus.frame_valid, bus.err);
    end
    reset = 1'b1;
    idle(5);
    checks++;
    if (digs() !== 16'hFFFF || fv_count !== 0) begin
      errors++; $display("FAIL reset_idle: got digits=%h frames=%0d want ffff 0", digs(), fv_count);
    end
  endtask

  task automatic test_clean_scan();
    int fv0 = fv_count;
    slot(3, seg_of(1), 1'b0, 10);
    slot(2, seg_of(2), 1'b1, 10);
    slot(1, seg_of(3), 1'b0, 10);
    drive(4'b0001, seg_of(4), 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.frame_valid !== (k == 6)) begin
        errors++; $display("FAIL clean_fv_timing cycle %0d: got %b want %b", k, bus.frame_valid, (k == 6));
      end
    end
    idle(5);
    checks++;
    if (fv_count - fv0 !== 1) begin errors++; $display("FAIL clean_frames: got %0d want 1", fv_count - fv0); end
    checks++;
    if (digs() !== 16'h1234) begin errors++; $display("FAIL clean_digits: got %h want 1234", digs()); end
    checks++;
    if (bus.dp_out !== 4'b0100) begin errors++; $display("FAIL clean_dp: got %b want 0100", bus.dp_out); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL clean_err: got %b want 0", bus.err); end
  endtask

  task automatic test_glitch();
    int fv0 = fv_count;
    slot(0, seg_of(9), 1'b0, 10);
    slot(2, seg_of(8), 1'b0, 10);
    slot(3, seg_of(0), 1'b0, 10);
    slot(1, seg_of(7), 1'b0, 3);
    slot(1, seg_of(5), 1'b0, 10);
    idle(5);
    checks++;
    if (fv_count - fv0 !== 1) begin errors++; $display("FAIL glitch_frames: got %0d want 1", fv_count - fv0); end
    checks++;
    if (digs() !== 16'h0859) begin errors++; $display("FAIL glitch_digits: got %h want 0859", digs()); end
    checks++;
    if (bus.err !== 1'b0 || bus.dp_out !== 4'b0000) begin
      errors++; $display("FAIL glitch_flags: got err=%b dp=%b want 0 0000", bus.err, bus.dp_out);
    end
  endtask

  task automatic test_invalid();
    slot(3, seg_of(1), 1'b0, 10);
    slot(2, seg_of(2), 1'b0, 10);
    slot(1, seg_of(3), 1'b0, 10);
    slot(0, 7'b1110010, 1'b0, 10);
    idle(5);
    checks++;
    if (digs() !== 16'h123E || bus.err !== 1'b1) begin
      errors++; $display("FAIL invalid_pattern: got %h err=%b want 123e err=1", digs(), bus.err);
    end
    drive(4'b0011, seg_of(8), 1'b0);
    repeat (10) @(negedge clk);
    scan_frame(5, 6, 7, 8, 4'b0000);
    checks++;
    if (digs() !== 16'h5678 || bus.err !== 1'b1) begin
      errors++; $display("FAIL multi_hot: got %h err=%b want 5678 err=1", digs(), bus.err);
    end
    scan_frame(4, 3, 2, 1, 4'b0000);
    checks++;
    if (digs() !== 16'h4321 || bus.err !== 1'b0) begin
      errors++; $display("FAIL err_cleared: got %h err=%b want 4321 err=0", digs(), bus.err);
    end
  endtask

  task automatic test_blanking();
    int fv0 = fv_count;
    slot(3, 7'b0000000, 1'b0, 10);
    idle(20);
    slot(2, seg_of(6), 1'b0, 10);
    idle(20);
    slot(1, seg_of(7), 1'b0, 10);
    idle(20);
    checks++;
    if (fv_count !== fv0) begin errors++; $display("FAIL blank_spurious: got %0d frames want 0", fv_count - fv0); end
    slot(0, seg_of(8), 1'b1, 10);
    idle(5);
    checks++;
    if (fv_count - fv0 !== 1) begin errors++; $display("FAIL blank_frames: got %0d want 1", fv_count - fv0); end
    checks++;
    if (digs() !== 16'hF678 || bus.dp_out !== 4'b0001) begin
      errors++; $display("FAIL blank_digits: got %h dp=%b want f678 0001", digs(), bus.dp_out);
    end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL blank_err: got %b want 0", bus.err); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    slot(0, seg_of(5), 1'b0, 10);
    slot(1, seg_of(6), 1'b0, 10);
    idle(3);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (digs() !== 16'hFFFF || bus.dp_out !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got %h dp=%b want ffff 0000", digs(), bus.dp_out);
    end
    #10 reset = 1'b1;
    @(negedge clk);
    fv0 = fv_count;
    slot(2, seg_of(2), 1'b0, 10);
    slot(3, seg_of(3), 1'b0, 10);
    idle(5);
    checks++;
    if (fv_count !== fv0 || digs() !== 16'hFFFF) begin
      errors++; $display("FAIL stale_slots: got frames=%0d digits=%h want 0 ffff", fv_count - fv0, digs());
    end
    slot(0, seg_of(1), 1'b0, 10);
    slot(1, seg_of(4), 1'b0, 10);
    idle(5);
    checks++;
    if (fv_count - fv0 !== 1 || digs() !== 16'h3241) begin
      errors++; $display("FAIL recapture: got frames=%0d digits=%h want 1 3241", fv_count - fv0, digs());
    end
  endtask

  task automatic test_long_hold();
    int fv0 = fv_count;
    slot(3, seg_of(7), 1'b0, 10);
    slot(2, seg_of(0), 1'b0, 10);
    slot(1, seg_of(1), 1'b0, 10);
    slot(0, seg_of(2), 1'b1, 300);
    checks++;
    if (fv_count - fv0 !== 1) begin errors++; $display("FAIL long_frames: got %0d want 1", fv_count - fv0); end
    checks++;
    if (digs() !== 16'h7012 || bus.dp_out !== 4'b0001) begin
      errors++; $display("FAIL long_digits: got %h dp=%b want 7012 0001", digs(), bus.dp_out);
    end
    idle(5);
    scan_frame(9, 8, 7, 6, 4'b1000);
    checks++;
    if (fv_count - fv0 !== 2 || digs() !== 16'h9876 || bus.dp_out !== 4'b1000) begin
      errors++; $display("FAIL after_long: got frames=%0d digits=%h dp=%b want 2 9876 1000",
                         fv_count - fv0, digs(), bus.dp_out);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(4'b0000, 7'b0000000, 1'b0);
    @(negedge clk);
    test_reset();
    test_clean_scan();
    test_glitch();
    test_invalid();
    test_blanking();
    test_reset_mid_frame();
    test_long_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
